// File: rtl/logic_lut_pkg.sv
// Shared types and constants for the LUT pipeline: output modes, default truth table, width helpers.
// No logic here; latency and backpressure live in logic_lut_pipe and lut_lane.
package logic_lut_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_INV  = 2'b01,
    MODE_EDGE = 2'b10,
    MODE_TGL  = 2'b11
  } mode_e;

  // Y = D & (~C | B), index {B,C,D}
  localparam logic [7:0] DEFAULT_TABLE = 8'hA2;

  function automatic int tbl_w(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/lut_lane.sv
// One channel: truth-table lookup plus output mode, result registered on the load strobe (1 cycle).
// No flow control of its own; the parent only asserts load when the output register may change.
module lut_lane
  import logic_lut_pkg::*;
#(
  parameter int                     N_IN       = 3,
  parameter logic [tbl_w(N_IN)-1:0] INIT_TABLE = DEFAULT_TABLE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [N_IN-1:0]        sel,
  input  logic                   cfg_we,
  input  logic [tbl_w(N_IN)-1:0] cfg_table,
  input  logic [1:0]             cfg_mode,
  output logic                   y
);

  logic [tbl_w(N_IN)-1:0] tt_q;
  mode_e                  mode_q;
  logic                   prev_q;
  logic                   tgl_q;
  logic                   f;
  logic                   y_nxt;

  assign f = tt_q[sel];

  always_comb begin
    y_nxt = f;
    case (mode_q)
      MODE_PASS: y_nxt = f;
      MODE_INV:  y_nxt = ~f;
      MODE_EDGE: y_nxt = f & ~prev_q;
      MODE_TGL:  y_nxt = tgl_q ^ f;
      default:   y_nxt = f;
    endcase
  end

  // A config write lands after the load terms so it wins on prev/toggle state,
  // while the load itself still evaluates with the old table and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q   <= INIT_TABLE;
      mode_q <= MODE_PASS;
      prev_q <= 1'b0;
      tgl_q  <= 1'b0;
      y      <= 1'b0;
    end else begin
      if (load) begin
        y <= y_nxt;
        if (mode_q == MODE_EDGE) prev_q <= f;
        if (mode_q == MODE_TGL)  tgl_q  <= y_nxt;
      end
      if (cfg_we) begin
        tt_q   <= cfg_table;
        mode_q <= mode_e'(cfg_mode);
        prev_q <= 1'b0;
        tgl_q  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/logic_lut_pipe.sv
// Multi-channel programmable Boolean unit: input register then LUT/mode output register, 2-cycle latency.
// Valid/ready both sides; a stalled output freezes both stages and in_ready drops once both are full.
module logic_lut_pipe
  import logic_lut_pkg::*;
#(
  parameter int                     N_IN       = 3,
  parameter int                     CHANNELS   = 4,
  parameter logic [tbl_w(N_IN)-1:0] INIT_TABLE = DEFAULT_TABLE,
  parameter int                     CNT_W      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*N_IN-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS-1:0]        out_data,
  input  logic                       cfg_we,
  input  logic [ch_w(CHANNELS)-1:0]  cfg_ch,
  input  logic [tbl_w(N_IN)-1:0]     cfg_table,
  input  logic [1:0]                 cfg_mode,
  output logic [CNT_W-1:0]           xfer_cnt
);

  logic                     s1_valid;
  logic [CHANNELS*N_IN-1:0] s1_data;
  logic                     in_fire;
  logic                     s2_load;

  assign in_ready = ~s1_valid | ~out_valid | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign s2_load  = s1_valid & (~out_valid | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_fire | (s1_valid & ~s2_load);
      if (in_fire) s1_data <= in_data;
      out_valid <= s2_load | (out_valid & ~out_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready && (xfer_cnt != {CNT_W{1'b1}})) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

  // Out-of-range cfg_ch matches no lane, so such writes are dropped.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    lut_lane #(
      .N_IN       (N_IN),
      .INIT_TABLE (INIT_TABLE)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (s2_load),
      .sel       (s1_data[c*N_IN +: N_IN]),
      .cfg_we    (cfg_we && (int'(cfg_ch) == c)),
      .cfg_table (cfg_table),
      .cfg_mode  (cfg_mode),
      .y         (out_data[c])
    );
  end

endmodule

// File: tb/tb_logic_lut_pipe.sv
// Directed bench for logic_lut_pipe; a second instance with a 2-bit counter covers saturation.
module tb_logic_lut_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cfg_we = 1'b0;
  logic [11:0] in_data = '0;
  logic [1:0]  cfg_ch = '0;
  logic [7:0]  cfg_table = '0;
  logic [1:0]  cfg_mode = '0;

  wire        in_ready, out_valid;
  wire [3:0]  out_data;
  wire [7:0]  xfer_cnt;
  wire        in_ready2, out_valid2;
  wire [3:0]  out_data2;
  wire [1:0]  xfer_cnt2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [3:0]  got_q[$];
  int          in_cyc_q[$];
  int          out_cyc_q[$];
  logic [11:0] stim[8];
  int          n_stim = 0;

  logic_lut_pipe #(.N_IN(3), .CHANNELS(4), .INIT_TABLE(8'hA2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_table(cfg_table), .cfg_mode(cfg_mode),
    .xfer_cnt(xfer_cnt)
  );

  logic_lut_pipe #(.N_IN(3), .CHANNELS(4), .INIT_TABLE(8'hA2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_table(cfg_table), .cfg_mode(cfg_mode),
    .xfer_cnt(xfer_cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) in_cyc_q.push_back(cyc);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        out_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    got_q.delete();
    in_cyc_q.delete();
    out_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    tick();
    tick();
    clear_q();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] tt, input logic [1:0] mode);
    cfg_we = 1'b1;
    cfg_ch = ch;
    cfg_table = tt;
    cfg_mode = mode;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic drive_stream();
    int guard;
    for (int i = 0; i < n_stim; i++) begin
      guard = 0;
      in_valid = 1'b1;
      in_data = stim[i];
      @(negedge clk);
      while (!in_ready && guard < 100) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 100) begin
        total++;
        bad++;
        $display("FAIL stream_accept: sample %0d in_ready=%b want 1 within 100 cycles", i, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 4'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++; if (xfer_cnt !== 8'h00) begin bad++; $display("FAIL reset_xfer_cnt: got %0d want 0", xfer_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (xfer_cnt2 !== 2'd0) begin bad++; $display("FAIL reset_xfer_cnt_sat: got %0d want 0", xfer_cnt2); end
  endtask

  task automatic test_defaults();
    logic [3:0] exp_d [5];
    exp_d = '{4'hF, 4'h0, 4'hF, 4'hF, 4'h0};
    do_reset();
    stim[0] = 12'h249; stim[1] = 12'h6DB; stim[2] = 12'hB6D; stim[3] = 12'hFFF; stim[4] = 12'h000;
    n_stim = 5;
    drive_stream();
    repeat (4) tick();
    total++; if (got_q.size() != 5) begin bad++; $display("FAIL defaults_count: got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size() && i < in_cyc_q.size()) begin
        total++;
        if (got_q[i] !== exp_d[i]) begin bad++; $display("FAIL defaults_data[%0d]: got %h want %h", i, got_q[i], exp_d[i]); end
        total++;
        if (out_cyc_q[i] - in_cyc_q[i] != 2) begin
          bad++; $display("FAIL defaults_latency[%0d]: got %0d want 2", i, out_cyc_q[i] - in_cyc_q[i]);
        end
      end
    end
    total++; if (xfer_cnt !== 8'd5) begin bad++; $display("FAIL defaults_xfer_cnt: got %0d want 5", xfer_cnt); end
    total++; if (xfer_cnt2 !== 2'd3) begin bad++; $display("FAIL sat_xfer_cnt: got %0d want 3", xfer_cnt2); end
  endtask

  task automatic test_reprogram();
    do_reset();
    cfg_write(2'd1, 8'h80, 2'b01);
    stim[0] = 12'hFFF; stim[1] = 12'h000;
    n_stim = 2;
    drive_stream();
    repeat (4) tick();
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL reprog_count: got %0d want 2", got_q.size()); end
    if (got_q.size() >= 2) begin
      total++; if (got_q[0] !== 4'hD) begin bad++; $display("FAIL reprog_ones: got %h want d", got_q[0]); end
      total++; if (got_q[1] !== 4'h2) begin bad++; $display("FAIL reprog_zeros: got %h want 2", got_q[1]); end
    end
  endtask

  task automatic test_edge_toggle();
    logic [3:0] exp_d [4];
    exp_d = '{4'hF, 4'h3, 4'h0, 4'hF};
    do_reset();
    cfg_write(2'd2, 8'hA2, 2'b10);
    cfg_write(2'd3, 8'hA2, 2'b11);
    stim[0] = 12'h249; stim[1] = 12'h249; stim[2] = 12'h000; stim[3] = 12'h249;
    n_stim = 4;
    drive_stream();
    repeat (4) tick();
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL edge_tgl_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        total++;
        if (got_q[i] !== exp_d[i]) begin bad++; $display("FAIL edge_tgl_data[%0d]: got %h want %h", i, got_q[i], exp_d[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_d [4];
    exp_d = '{4'hA, 4'hF, 4'h0, 4'h1};
    do_reset();
    out_ready = 1'b0;
    stim[0] = 12'h2E8; stim[1] = 12'hFFF; stim[2] = 12'h6DB; stim[3] = 12'h001;
    n_stim = 4;
    fork
      drive_stream();
      begin
        repeat (3) tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
        total++; if (out_data !== 4'hA) begin bad++; $display("FAIL bp_hold_early: got %h want a", out_data); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        repeat (2) tick();
        total++; if (out_data !== 4'hA) begin bad++; $display("FAIL bp_hold_late: got %h want a", out_data); end
        total++; if (in_cyc_q.size() != 2) begin bad++; $display("FAIL bp_accepts: got %0d want 2", in_cyc_q.size()); end
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();
    total++; if (got_q.size() != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        total++;
        if (got_q[i] !== exp_d[i]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_d[i]); end
      end
    end
    total++; if (xfer_cnt !== 8'd4) begin bad++; $display("FAIL bp_xfer_cnt: got %0d want 4", xfer_cnt); end
  endtask

  task automatic test_collision();
    logic [3:0] exp_d [3];
    exp_d = '{4'hF, 4'hE, 4'hE};
    do_reset();
    stim[0] = 12'hFFF; stim[1] = 12'hFFF; stim[2] = 12'hFFF;
    n_stim = 3;
    fork
      drive_stream();
      begin
        tick();
        cfg_write(2'd0, 8'h00, 2'b00);
      end
    join
    repeat (4) tick();
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL collide_count: got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) begin
        total++;
        if (got_q[i] !== exp_d[i]) begin bad++; $display("FAIL collide_data[%0d]: got %h want %h", i, got_q[i], exp_d[i]); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    cfg_write(2'd0, 8'h00, 2'b00);
    in_valid = 1'b1;
    in_data = 12'hFFF;
    repeat (4) tick();
    total++; if (out_data !== 4'hE) begin bad++; $display("FAIL mid_pre_data: got %h want e", out_data); end
    total++; if (xfer_cnt !== 8'd2) begin bad++; $display("FAIL mid_pre_cnt: got %0d want 2", xfer_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    total++; if (xfer_cnt !== 8'd0) begin bad++; $display("FAIL mid_xfer_cnt: got %0d want 0", xfer_cnt); end
    total++; if (xfer_cnt2 !== 2'd0) begin bad++; $display("FAIL mid_xfer_cnt_sat: got %0d want 0", xfer_cnt2); end
    total++; if (out_data !== 4'h0) begin bad++; $display("FAIL mid_out_data: got %h want 0", out_data); end
    in_valid = 1'b0;
    tick();
    clear_q();
    rst_n = 1'b1;
    tick();
    stim[0] = 12'hFFF;
    n_stim = 1;
    drive_stream();
    repeat (4) tick();
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL mid_post_count: got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      total++; if (got_q[0] !== 4'hF) begin bad++; $display("FAIL mid_post_table: got %h want f", got_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_reprogram();
    test_edge_toggle();
    test_backpressure();
    test_collision();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached, done=0 want 1");
    $fatal(1);
  end

endmodule
